// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and position payload type.
// Imported by vga_timing_gen, vga_pix_en_gen and vga_bitchange, which uses the
// same screen-edge values.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;     // hCount / vCount width
    localparam int unsigned DIV_W = 4;      // divider width, covers CLK_DIV up to 16

    localparam int unsigned VGA_CLK_DIV      = 4;
    localparam int unsigned VGA_H_TOTAL      = 800;
    localparam int unsigned VGA_H_SYNC       = 96;
    localparam int unsigned VGA_H_DISP_START = 144;
    localparam int unsigned VGA_H_DISP_END   = 784;
    localparam int unsigned VGA_V_TOTAL      = 525;
    localparam int unsigned VGA_V_SYNC       = 2;
    localparam int unsigned VGA_V_DISP_START = 35;
    localparam int unsigned VGA_V_DISP_END   = 515;

    typedef logic [CNT_W-1:0] cnt_t;

    // Raster position carried between the counter logic and its decoders.
    typedef struct packed {
        cnt_t h;
        cnt_t v;
    } vga_pos_t;

    // lo <= x < hi, evaluated in 32 bits so an upper bound of 1024 is exact.
    function automatic logic in_window(cnt_t x, int unsigned lo, int unsigned hi);
        return (32'(x) >= lo) && (32'(x) < hi);
    endfunction

endpackage

// File: rtl/vga_pix_en_gen.sv
// Pixel-rate strobe generator: divides clk by CLK_DIV.
// Ports:
//   clk, rst      - system clock, async active-low reset
//   pix_en        - registered one-clk pulse every CLK_DIV clocks
//   pix_stb_c     - combinational: pix_en will be high after the next edge;
//                   lets the raster counters move on the same edge as pix_en
module vga_pix_en_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = VGA_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en,
    output logic pix_stb_c
);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q, pix_en_d;

    // Divider wraps at CLK_DIV-1; with CLK_DIV=1 it stays at 0 and strobes every clock.
    always_comb begin
        pix_stb_c = (div_q == DIV_W'(CLK_DIV - 1));
        div_d     = pix_stb_c ? '0 : div_q + DIV_W'(1);
        pix_en_d  = pix_stb_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
        end
    end

    assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 Hz by default).
// Ports:
//   clk, rst        - system clock, async active-low reset
//   pix_en          - pixel-rate strobe
//   hCount, vCount  - raster position
//   hSync, vSync    - active-low syncs
//   bright          - inside visible window
//   frame_tick      - one-clk pulse when the raster wraps to (0,0)
// Optional: define VGA_FRAME_TICK_EN to build frame_tick; otherwise it is tied 0.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV      = VGA_CLK_DIV,
    parameter int unsigned H_TOTAL      = VGA_H_TOTAL,
    parameter int unsigned H_SYNC       = VGA_H_SYNC,
    parameter int unsigned H_DISP_START = VGA_H_DISP_START,
    parameter int unsigned H_DISP_END   = VGA_H_DISP_END,
    parameter int unsigned V_TOTAL      = VGA_V_TOTAL,
    parameter int unsigned V_SYNC       = VGA_V_SYNC,
    parameter int unsigned V_DISP_START = VGA_V_DISP_START,
    parameter int unsigned V_DISP_END   = VGA_V_DISP_END
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             hSync,
    output logic             vSync,
    output logic             bright,
    output logic             frame_tick
);

    logic     pix_stb_c;
    vga_pos_t pos_q, pos_d;
    logic     hsync_q, hsync_d;
    logic     vsync_q, vsync_d;
    logic     bright_q, bright_d;
    logic     last_px_c;

    vga_pix_en_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_en (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .pix_stb_c (pix_stb_c)
    );

    // Next raster position; moves on the same edge that raises pix_en.
    always_comb begin
        pos_d     = pos_q;
        last_px_c = (pos_q.h == CNT_W'(H_TOTAL - 1)) && (pos_q.v == CNT_W'(V_TOTAL - 1));
        if (pix_stb_c) begin
            if (pos_q.h == CNT_W'(H_TOTAL - 1)) begin
                pos_d.h = '0;
                if (pos_q.v == CNT_W'(V_TOTAL - 1)) begin
                    pos_d.v = '0;
                end else begin
                    pos_d.v = pos_q.v + CNT_W'(1);
                end
            end else begin
                pos_d.h = pos_q.h + CNT_W'(1);
            end
        end
    end

    // Decode from the next position so sync/bright flip together with the counters.
    always_comb begin
        hsync_d  = (32'(pos_d.h) >= H_SYNC);
        vsync_d  = (32'(pos_d.v) >= V_SYNC);
        bright_d = in_window(pos_d.h, H_DISP_START, H_DISP_END) &&
                   in_window(pos_d.v, V_DISP_START, V_DISP_END);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_q    <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            bright_q <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            bright_q <= bright_d;
        end
    end

`ifdef VGA_FRAME_TICK_EN
    logic frame_tick_q, frame_tick_d;

    // Pulse only on a real wrap from the last pixel, never from reset release.
    always_comb begin
        frame_tick_d = pix_stb_c && last_px_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_tick_d;
        end
    end

    assign frame_tick = frame_tick_q;
`else
    logic unused_last_px;
    assign unused_last_px = last_px_c;
    assign frame_tick     = 1'b0;
`endif

    assign hCount = pos_q.h;
    assign vCount = pos_q.v;
    assign hSync  = hsync_q;
    assign vSync  = vsync_q;
    assign bright = bright_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. Horizontal timing and divider use the
// real 640x480 values; the frame is shortened vertically so several frame
// wraps fit in a short run.
module tb_vga_timing_gen;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned HT  = 800;
    localparam int unsigned HS  = 96;
    localparam int unsigned HDS = 144;
    localparam int unsigned HDE = 784;
    localparam int unsigned VT  = 6;
    localparam int unsigned VS  = 1;
    localparam int unsigned VDS = 2;
    localparam int unsigned VDE = 5;
    localparam longint FRAME_PX = longint'(HT) * longint'(VT);

    logic       clk;
    logic       rst;
    logic       pix_en;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       bright;
    logic       frame_tick;

    vga_timing_gen #(
        .CLK_DIV      (CLK_DIV),
        .H_TOTAL      (HT),
        .H_SYNC       (HS),
        .H_DISP_START (HDS),
        .H_DISP_END   (HDE),
        .V_TOTAL      (VT),
        .V_SYNC       (VS),
        .V_DISP_START (VDS),
        .V_DISP_END   (VDE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .hCount     (hcount),
        .vCount     (vcount),
        .hSync      (hsync),
        .vSync      (vsync),
        .bright     (bright),
        .frame_tick (frame_tick)
    );

    typedef struct {
        bit pe;
        int h;
        int v;
        bit hs;
        bit vs;
        bit br;
        bit ft;
    } exp_t;

    exp_t   sb[$];
    int     n_chk  = 0;
    int     n_fail = 0;
    int     n_push = 0;
    int     n_pop  = 0;
    int     exp_ticks = 0;
    int     seen_ticks = 0;
    longint k = 0;      // clock edges since reset release

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: everything follows from the number of edges since release.
    function automatic exp_t model(longint edges);
        exp_t   e;
        longint p;
        p    = edges / CLK_DIV;
        e.pe = (edges > 0) && (edges % CLK_DIV == 0);
        e.h  = int'(p % HT);
        e.v  = int'((p / HT) % VT);
        e.hs = !(e.h < int'(HS));
        e.vs = !(e.v < int'(VS));
        e.br = (e.h >= int'(HDS)) && (e.h < int'(HDE)) && (e.v >= int'(VDS)) && (e.v < int'(VDE));
`ifdef VGA_FRAME_TICK_EN
        e.ft = e.pe && (p > 0) && (p % FRAME_PX == 0);
`else
        e.ft = 1'b0;
`endif
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0d required=%0d (k=%0d)", nm, $time, act, req, k);
        end
    endtask

    // One clock: DUT edge, then mid-cycle drive of rst, then post the expectation.
    task automatic step(input logic r);
        exp_t e;
        @(posedge clk);
        if (rst) k++;
        #2;
        rst = r;
        if (!r) k = 0;
        e = model(k);
        if (e.ft) exp_ticks++;
        sb.push_back(e);
        n_push++;
    endtask

    // Monitor: compare every presented output set against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_pop++;
                chk("pix_en",     32'(pix_en),     32'(e.pe));
                chk("hCount",     32'(hcount),     32'(e.h));
                chk("vCount",     32'(vcount),     32'(e.v));
                chk("hSync",      32'(hsync),      32'(e.hs));
                chk("vSync",      32'(vsync),      32'(e.vs));
                chk("bright",     32'(bright),     32'(e.br));
                chk("frame_tick", 32'(frame_tick), 32'(e.ft));
                if (frame_tick === 1'b1) seen_ticks++;
            end
        end
    end

    initial begin
        int run;
        int hold;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) step(1'b0);
        step(1'b1);
        // Two full frames plus margin: line wraps, frame wraps, window edges.
        repeat (int'(2 * FRAME_PX * CLK_DIV) + 400) step(1'b1);
        // Random mid-frame resets with random hold times.
        for (int i = 0; i < 4; i++) begin
            run  = int'($urandom_range(5000, 50));
            hold = int'($urandom_range(4, 1));
            repeat (run) step(1'b1);
            repeat (hold) step(1'b0);
            step(1'b1);
        end
        // First line after the last reset, through the 799 -> 0 wrap.
        repeat (HT * CLK_DIV + 100) step(1'b1);
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("pop_count",  32'(n_pop),     32'(n_push));
        chk("tick_total", 32'(seen_ticks), 32'(exp_ticks));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
